// File: rtl/fp16_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_to_int
//  Description : Multi-cycle converter from a 16-bit float (sign, 8-bit
//                exponent with bias 127, 7-bit fraction with hidden 1) to a
//                saturating two's-complement integer, truncating toward zero.
//                The mantissa is aligned one bit per cycle. Results are held
//                until the consumer accepts them.
//  Ports       : clock     - single clock, rising edge
//                reset     - synchronous, active-high
//                in_data   - float operand (sign N-1, exp [14:7], frac [6:0])
//                in_valid  - operand valid
//                in_ready  - block idle and able to accept an operand
//                out_data  - signed integer result
//                out_valid - out_data / overflow / inexact valid
//                out_ready - consumer accepts the result
//                overflow  - result was saturated
//                inexact   - nonzero fraction bits were discarded
//  Revision    : 1.0 - initial release
// ============================================================================
module fp16_to_int #(
    parameter int N     = 16,
    parameter int OUT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             inexact
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_align = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    localparam logic [7:0] c_bias    = 8'd127;
    // Exponent at which {1,frac} is already an integer (e == 7).
    localparam logic [7:0] c_exp_int = 8'd134;
    // First exponent that no longer fits a signed OUT_W result (e == OUT_W-1).
    localparam logic [7:0] c_sat_exp = 8'(127 + OUT_W - 1);

    localparam logic [OUT_W-1:0] c_max = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] c_min = {1'b1, {(OUT_W-1){1'b0}}};

    logic [1:0]       r_state;
    logic [1:0]       w_next;

    logic             r_sign;
    logic [OUT_W-1:0] r_mag;
    logic [7:0]       r_cnt;
    logic             r_left;
    logic             r_sticky;
    logic             r_force;
    logic [OUT_W-1:0] r_force_data;
    logic             r_force_ovf;
    logic             r_force_inx;
    logic [OUT_W-1:0] r_out_data;
    logic             r_overflow;
    logic             r_inexact;

    logic             w_sign;
    logic [7:0]       w_exp;
    logic [6:0]       w_frac;
    logic [OUT_W-1:0] w_mag_init;
    logic [7:0]       w_cnt;
    logic             w_left;
    logic             w_force;
    logic [OUT_W-1:0] w_force_data;
    logic             w_force_ovf;
    logic             w_force_inx;
    logic             w_accept;

    assign w_sign     = in_data[N-1];
    assign w_exp      = in_data[14:7];
    assign w_frac     = in_data[6:0];
    assign w_mag_init = {{(OUT_W-8){1'b0}}, 1'b1, w_frac};
    assign w_accept   = (r_state == c_idle) && in_valid;

    // Operand classification: special encodings bypass alignment (cnt = 0)
    // and carry a forced result; ordinary operands get a shift count and
    // direction relative to the integer-aligned exponent.
    always_comb begin
        w_cnt        = 8'd0;
        w_left       = 1'b0;
        w_force      = 1'b0;
        w_force_data = '0;
        w_force_ovf  = 1'b0;
        w_force_inx  = 1'b0;
        if (w_exp == 8'd0) begin
            w_force     = 1'b1;
            w_force_inx = (w_frac != 7'd0);
        end else if (w_exp == 8'd255) begin
            w_force      = 1'b1;
            w_force_data = w_sign ? c_min : c_max;
            w_force_ovf  = 1'b1;
        end else if (w_exp < c_bias) begin
            // |value| in (0,1): truncates to zero, always inexact
            w_force     = 1'b1;
            w_force_inx = 1'b1;
        end else if (w_exp >= c_sat_exp) begin
            w_force      = 1'b1;
            w_force_data = w_sign ? c_min : c_max;
            // Exactly the most negative integer is representable.
            w_force_ovf  = !(w_sign && (w_exp == c_sat_exp) && (w_frac == 7'd0));
        end else if (w_exp < c_exp_int) begin
            w_cnt = c_exp_int - w_exp;
        end else begin
            w_left = 1'b1;
            w_cnt  = w_exp - c_exp_int;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  if (in_valid)       w_next = c_align;
            c_align: if (r_cnt == 8'd0)  w_next = c_done;
            c_done:  if (out_ready)      w_next = c_idle;
            default:                     w_next = c_idle;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (r_state == c_idle);
        out_valid = (r_state == c_done);
    end

    // Datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sign       <= 1'b0;
            r_mag        <= '0;
            r_cnt        <= 8'd0;
            r_left       <= 1'b0;
            r_sticky     <= 1'b0;
            r_force      <= 1'b0;
            r_force_data <= '0;
            r_force_ovf  <= 1'b0;
            r_force_inx  <= 1'b0;
            r_out_data   <= '0;
            r_overflow   <= 1'b0;
            r_inexact    <= 1'b0;
        end else if (w_accept) begin
            r_sign       <= w_sign;
            r_mag        <= w_mag_init;
            r_cnt        <= w_cnt;
            r_left       <= w_left;
            r_sticky     <= 1'b0;
            r_force      <= w_force;
            r_force_data <= w_force_data;
            r_force_ovf  <= w_force_ovf;
            r_force_inx  <= w_force_inx;
        end else if (r_state == c_align) begin
            if (r_cnt != 8'd0) begin
                if (r_left) begin
                    r_mag <= r_mag << 1;
                end else begin
                    r_mag    <= r_mag >> 1;
                    r_sticky <= r_sticky | r_mag[0];
                end
                r_cnt <= r_cnt - 8'd1;
            end else if (r_force) begin
                r_out_data <= r_force_data;
                r_overflow <= r_force_ovf;
                r_inexact  <= r_force_inx;
            end else begin
                // Negate the already-truncated magnitude: rounds toward zero.
                r_out_data <= r_sign ? -r_mag : r_mag;
                r_overflow <= 1'b0;
                r_inexact  <= r_sticky;
            end
        end
    end

    assign out_data = r_out_data;
    assign overflow = r_overflow;
    assign inexact  = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_fp16_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp16_to_int
//  Description : Self-checking bench for fp16_to_int: directed vector table,
//                hold / reset sequences and random operands against a
//                value-range reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_to_int;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        inexact;

    int n_vec = 0;
    int n_err = 0;

    fp16_to_int #(.N(16), .OUT_W(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow (overflow),
        .inexact  (inexact)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
        logic        ovf;
        logic        inx;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference: value = 1.frac * 2^(exp-127), truncated toward zero, then
    // clamped into the signed 16-bit range.
    task automatic model(input logic [15:0] din, output logic [15:0] dout,
                         output logic ovf, output logic inx, output int lat);
        logic       s;
        int         ex;
        int         fr;
        int         e;
        longint     full;
        longint     mag;
        longint     v;
        s   = din[15];
        ex  = int'(din[14:7]);
        fr  = int'(din[6:0]);
        ovf = 1'b0;
        inx = 1'b0;
        lat = 1;
        v   = 0;
        e   = ex - 127;
        if (ex == 0) begin
            inx = (fr != 0);
        end else if (ex == 255 || e >= 16) begin
            v   = s ? -32768 : 32767;
            ovf = 1'b1;
        end else if (e < 0) begin
            inx = 1'b1;
        end else begin
            full = 128 + fr;
            if (e >= 7) begin
                mag = full << (e - 7);
            end else begin
                mag = full >> (7 - e);
                inx = ((mag << (7 - e)) != full);
            end
            v = s ? -mag : mag;
            if (v > 32767) begin
                v = 32767; ovf = 1'b1; inx = 1'b0;
            end else if (v < -32768) begin
                v = -32768; ovf = 1'b1; inx = 1'b0;
            end else if (e <= 14) begin
                lat = ((e > 7) ? (e - 7) : (7 - e)) + 1;
            end
        end
        dout = v[15:0];
    endtask

    // One full transaction. While the result waits in DONE for `hold` cycles
    // the bench offers junk operands, which must be ignored; the release
    // edge also has in_valid high and must not start a new operation.
    task automatic run_op(input logic [15:0] din, input int hold,
                          output logic [15:0] dout, output logic ovf,
                          output logic inx, output int lat);
        string tag;
        tag = $sformatf("op %04h", din);
        in_data  = din;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        dout = out_data;
        ovf  = overflow;
        inx  = inexact;
        if (!out_valid) begin
            chk({tag, " timeout"}, 32'd0, 32'd1);
            lat = -1;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            in_data  = 16'($urandom);
            in_valid = 1'b1;
            @(posedge clock); #1;
            chk({tag, " hold data"}, 32'(out_data), 32'(dout));
            chk({tag, " hold flags"}, {29'd0, out_valid, overflow, inexact}, {29'd0, 1'b1, ovf, inx});
            chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, " release"}, {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[$];
        logic [15:0] d;
        logic        o;
        logic        x;
        int          l;
        logic [15:0] md;
        logic        mo;
        logic        mx;
        int          ml;
        logic [15:0] din;

        reset     = 1'b1;
        in_data   = 16'h0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        tbl.push_back('{16'h3F80, 16'h0001, 1'b0, 1'b0, 8});
        tbl.push_back('{16'h4020, 16'h0002, 1'b0, 1'b1, 7});
        tbl.push_back('{16'hC020, 16'hFFFE, 1'b0, 1'b1, 7});
        tbl.push_back('{16'hC700, 16'h8000, 1'b0, 1'b0, 1});
        tbl.push_back('{16'h4700, 16'h7FFF, 1'b1, 1'b0, 1});
        tbl.push_back('{16'h7F80, 16'h7FFF, 1'b1, 1'b0, 1});
        tbl.push_back('{16'hFF80, 16'h8000, 1'b1, 1'b0, 1});
        tbl.push_back('{16'h3F40, 16'h0000, 1'b0, 1'b1, 1});
        tbl.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 1});
        tbl.push_back('{16'h0001, 16'h0000, 1'b0, 1'b1, 1});
        tbl.push_back('{16'h46FF, 16'h7F80, 1'b0, 1'b0, 8});
        tbl.push_back('{16'hC6FF, 16'h8080, 1'b0, 1'b0, 8});
        tbl.push_back('{16'hC701, 16'h8000, 1'b1, 1'b0, 1});
        tbl.push_back('{16'h4300, 16'h0080, 1'b0, 1'b0, 1});
        tbl.push_back('{16'h3FFF, 16'h0001, 1'b0, 1'b1, 8});
        tbl.push_back('{16'h7FC1, 16'h7FFF, 1'b1, 1'b0, 1});

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset flags", {29'd0, out_valid, overflow, inexact}, 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        // Directed table
        foreach (tbl[i]) begin
            run_op(tbl[i].din, 1, d, o, x, l);
            chk($sformatf("vec %04h data", tbl[i].din), 32'(d), 32'(tbl[i].dout));
            chk($sformatf("vec %04h ovf", tbl[i].din), 32'(o), 32'(tbl[i].ovf));
            chk($sformatf("vec %04h inx", tbl[i].din), 32'(x), 32'(tbl[i].inx));
            chk($sformatf("vec %04h lat", tbl[i].din), 32'(l), 32'(tbl[i].lat));
        end

        // Long back-pressure in DONE
        run_op(16'h4020, 5, d, o, x, l);
        chk("hold5 data", 32'(d), 32'h2);

        // Reset in the middle of alignment
        in_data  = 16'h3F80;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midreset out_data", 32'(out_data), 32'd0);
        chk("midreset flags", {29'd0, out_valid, overflow, inexact}, 32'd0);
        chk("midreset in_ready", 32'(in_ready), 32'd1);
        repeat (8) begin
            @(posedge clock); #1;
            chk("midreset no result", 32'(out_valid), 32'd0);
        end
        run_op(16'h4020, 0, d, o, x, l);
        chk("post-reset data", 32'(d), 32'h2);
        chk("post-reset inx", 32'(x), 32'd1);
        chk("post-reset lat", 32'(l), 32'd7);

        // Random operands, biased toward the convertible exponent range
        for (int k = 0; k < 300; k++) begin
            din = 16'($urandom);
            if (k % 2 == 0) din[14:7] = 8'($urandom_range(120, 145));
            model(din, md, mo, mx, ml);
            run_op(din, int'($urandom_range(0, 3)), d, o, x, l);
            chk($sformatf("rnd %04h data", din), 32'(d), 32'(md));
            chk($sformatf("rnd %04h flags", din), {30'd0, o, x}, {30'd0, mo, mx});
            chk($sformatf("rnd %04h lat", din), 32'(l), 32'(ml));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
